cmp_sar_search: RTL and testbench

//  Successive-approximation (binary search) controller on the consuming end of
//  the eq/lt/gt magnitude-compare interface. Issues trial words to an external

---
 rtl/cmp_sar_search_if.sv | 22 ++
 rtl/cmp_sar_search.sv | 139 +++++++++++++
 tb/tb_cmp_sar_search.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_sar_search_if.sv
// Trial/verdict channel between the SAR search controller and a magnitude comparator.
// The master side issues trial words; the slave side answers with eq/lt/gt.
interface cmp_sar_search_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] trial;
   logic             trial_valid;
   logic             cmp_valid;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             cmp_gt;

   modport master (
      output trial, trial_valid,
      input  cmp_valid, cmp_eq, cmp_lt, cmp_gt
   );

   modport slave (
      input  trial, trial_valid,
      output cmp_valid, cmp_eq, cmp_lt, cmp_gt
   );
endinterface

// File: rtl/cmp_sar_search.sv
// Successive-approximation (binary search) controller driving an external
// eq/lt/gt comparator. Narrows [lo,hi] until eq is seen or the range empties.
// Optional feature macro: CMP_SAR_TIMEOUT_EN -- abort with error when the
// comparator stays silent for TIMEOUT cycles while a trial is outstanding.
module cmp_sar_search #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16,
   localparam int SW     = $clog2(WIDTH + 2)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   cmp_sar_search_if.master     bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_found,
   output logic                 o_error,
   output logic [WIDTH-1:0]     o_result,
   output logic [SW-1:0]        o_steps
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH:0]   r_lo;
   logic [WIDTH:0]   r_hi;
   logic             r_tv;
   logic             r_done;
   logic             r_found;
   logic             r_error;
   logic [WIDTH-1:0] r_result;
   logic [SW-1:0]    r_steps;

   logic [WIDTH:0]   w_span;
   logic [WIDTH-1:0] w_trial;
   logic [WIDTH:0]   w_lo_inc;
   logic [WIDTH:0]   w_hi_dec;
   logic             w_onehot;
   logic             w_exh_lt;
   logic             w_exh_gt;

   // lo is never negative and hi never exceeds 2^WIDTH-1, so widening by one
   // more bit keeps lo=2^WIDTH from looking negative while hi=-1 still does.
   function automatic logic f_exh(input logic [WIDTH:0] lo, input logic [WIDTH:0] hi);
      return $signed({1'b0, lo}) > $signed({hi[WIDTH], hi});
   endfunction

   // Midpoint trial and the candidate bound updates for the current verdict.
   always_comb begin
      w_span   = r_hi - r_lo;
      w_trial  = WIDTH'(r_lo + (w_span >> 1));
      w_lo_inc = {1'b0, w_trial} + (WIDTH+1)'(1);
      w_hi_dec = {1'b0, w_trial} - (WIDTH+1)'(1);
      w_onehot = ({1'b0, bus.cmp_eq} + {1'b0, bus.cmp_lt} + {1'b0, bus.cmp_gt}) == 2'd1;
      w_exh_lt = f_exh(w_lo_inc, r_hi);
      w_exh_gt = f_exh(r_lo, w_hi_dec);
   end

`ifdef CMP_SAR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tmo;
`endif

   // Search FSM: all outputs registered; done is high only in the DONE state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_lo     <= '0;
         r_hi     <= {1'b0, {WIDTH{1'b1}}};
         r_tv     <= 1'b0;
         r_done   <= 1'b0;
         r_found  <= 1'b0;
         r_error  <= 1'b0;
         r_result <= '0;
         r_steps  <= '0;
`ifdef CMP_SAR_TIMEOUT_EN
         r_tmo    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_REQ;
                  r_lo    <= '0;
                  r_hi    <= {1'b0, {WIDTH{1'b1}}};
                  r_found <= 1'b0;
                  r_error <= 1'b0;
                  r_steps <= '0;
                  r_tv    <= 1'b1;
`ifdef CMP_SAR_TIMEOUT_EN
                  r_tmo   <= '0;
`endif
               end
            end
            S_REQ: begin
               if (bus.cmp_valid) begin
                  r_steps  <= r_steps + SW'(1);
                  r_result <= w_trial;
`ifdef CMP_SAR_TIMEOUT_EN
                  r_tmo    <= '0;
`endif
                  if (!w_onehot || bus.cmp_eq || (bus.cmp_lt && w_exh_lt) ||
                      (bus.cmp_gt && w_exh_gt)) begin
                     r_state <= S_DONE;
                     r_tv    <= 1'b0;
                     r_done  <= 1'b1;
                  end
                  // A malformed verdict leaves the bounds untouched.
                  if (!w_onehot)        r_error <= 1'b1;
                  else if (bus.cmp_eq)  r_found <= 1'b1;
                  else if (bus.cmp_lt)  r_lo    <= w_lo_inc;
                  else                  r_hi    <= w_hi_dec;
               end
`ifdef CMP_SAR_TIMEOUT_EN
               else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_state <= S_DONE;
                  r_tv    <= 1'b0;
                  r_done  <= 1'b1;
                  r_error <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
`endif
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.trial       = w_trial;
   assign bus.trial_valid = r_tv;
   assign o_busy          = r_tv;
   assign o_done          = r_done;
   assign o_found         = r_found;
   assign o_error         = r_error;
   assign o_result        = r_result;
   assign o_steps         = r_steps;
endmodule

// File: tb/tb_cmp_sar_search.sv
// Randomized bench for cmp_sar_search: a comparator responder answers at the
// negative edge, and an integer binary-search model predicts trials and results.
module tb_cmp_sar_search;
   localparam int WIDTH = 8;
   localparam int SW    = $clog2(WIDTH + 2);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             busy, done, found, error;
   logic [WIDTH-1:0] result;
   logic [SW-1:0]    steps;

   int n_chk = 0;
   int n_err = 0;

   cmp_sar_search_if #(.WIDTH(WIDTH)) ifc ();

   cmp_sar_search #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_start  (start),
      .bus      (ifc.master),
      .o_busy   (busy),
      .o_done   (done),
      .o_found  (found),
      .o_error  (error),
      .o_result (result),
      .o_steps  (steps)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic quiet_cmp();
      ifc.cmp_valid = 1'b0;
      ifc.cmp_eq    = 1'b0;
      ifc.cmp_lt    = 1'b0;
      ifc.cmp_gt    = 1'b0;
   endtask

   // mode 0: honest comparator vs tgt; 1: always lt; 2: lt&gt on accept bad_at.
   // dly >= 0 fixed wait per trial, dly < 0 random 0..3.
   task automatic run_search(input int tgt, input int mode, input int bad_at, input int dly);
      int exp_q[$];
      int lo, hi, mid, n, er, idx, wait_c;
      bit ef, ee, have, got_done;
      logic [WIDTH-1:0] held;
      lo = 0; hi = (1 << WIDTH) - 1; n = 0; er = 0; ef = 0; ee = 0;
      while (lo <= hi) begin
         mid = (lo + hi) / 2;
         exp_q.push_back(mid);
         n++;
         er = mid;
         if (mode == 2 && n == bad_at) begin ee = 1; break; end
         if (mode == 0 && mid == tgt) begin ef = 1; break; end
         if (mode == 1 || mid < tgt) lo = mid + 1;
         else hi = mid - 1;
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", {31'b0, busy}, 1);
      idx = 0; have = 0; got_done = 0; wait_c = 0; held = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (done) begin got_done = 1; break; end
         quiet_cmp();
         start = 1'b0;
         if (ifc.trial_valid) begin
            if (!have) begin
               have   = 1;
               held   = ifc.trial;
               wait_c = (dly >= 0) ? dly : int'($urandom_range(0, 3));
               if (idx < exp_q.size()) chk("trial", {24'b0, ifc.trial}, exp_q[idx]);
               else chk("extra_trial", idx, exp_q.size());
            end else begin
               chk("trial_held", {24'b0, ifc.trial}, {24'b0, held});
            end
            if (wait_c > 0) begin
               wait_c--;
               start = 1'b1;
            end else begin
               ifc.cmp_valid = 1'b1;
               if (mode == 2 && idx + 1 == bad_at) begin
                  ifc.cmp_lt = 1'b1; ifc.cmp_gt = 1'b1;
               end else if (mode == 1) begin
                  ifc.cmp_lt = 1'b1;
               end else begin
                  ifc.cmp_eq = (int'(held) == tgt);
                  ifc.cmp_lt = (int'(held) <  tgt);
                  ifc.cmp_gt = (int'(held) >  tgt);
               end
               idx++;
               have = 0;
            end
         end
         @(negedge clk);
      end
      quiet_cmp();
      start = 1'b0;
      chk("done_seen", {31'b0, got_done}, 1);
      chk("n_trials", idx, exp_q.size());
      chk("found", {31'b0, found}, {31'b0, ef});
      chk("error", {31'b0, error}, {31'b0, ee});
      chk("result", {24'b0, result}, er);
      chk("steps", {28'b0, steps}, n);
      chk("busy_at_done", {31'b0, busy}, 0);
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 0);
      chk("found_held", {31'b0, found}, {31'b0, ef});
      chk("result_held", {24'b0, result}, er);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      quiet_cmp();
      #12;
      chk("rst_busy",   {31'b0, busy}, 0);
      chk("rst_tv",     {31'b0, ifc.trial_valid}, 0);
      chk("rst_done",   {31'b0, done}, 0);
      chk("rst_found",  {31'b0, found}, 0);
      chk("rst_error",  {31'b0, error}, 0);
      chk("rst_result", {24'b0, result}, 0);
      chk("rst_steps",  {28'b0, steps}, 0);
      chk("rst_trial",  {24'b0, ifc.trial}, 32'h7F);
      @(negedge clk); rst_n = 1'b1;

      run_search(32'h5A, 0, 0, 0);
      run_search(32'hFF, 0, 0, 0);
      run_search(32'h00, 0, 0, 0);
      run_search(0, 1, 0, 0);
      run_search(32'h10, 2, 2, 3);

      // Abort mid-search with reset, then confirm a fresh search.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ifc.cmp_valid = 1'b1; ifc.cmp_gt = 1'b1;
         @(negedge clk);
      end
      quiet_cmp();
      chk("mid_busy", {31'b0, busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy",  {31'b0, busy}, 0);
      chk("abort_steps", {28'b0, steps}, 0);
      chk("abort_res",   {24'b0, result}, 0);
      chk("abort_trial", {24'b0, ifc.trial}, 32'h7F);
      @(negedge clk); rst_n = 1'b1;
      // A verdict offered while idle must be ignored.
      ifc.cmp_valid = 1'b1; ifc.cmp_lt = 1'b1;
      @(negedge clk);
      quiet_cmp();
      chk("idle_ignore_trial", {24'b0, ifc.trial}, 32'h7F);
      chk("idle_ignore_steps", {28'b0, steps}, 0);
      chk("idle_ignore_busy",  {31'b0, busy}, 0);
      run_search(32'h5A, 0, 0, 0);

      for (int r = 0; r < 20; r++)
         run_search(int'($urandom_range(0, 255)), 0, 0, -1);

`ifdef CMP_SAR_TIMEOUT_EN
      begin
         bit seen;
         seen = 0;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int c = 0; c < 40; c++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
         end
         chk("tmo_done",  {31'b0, seen}, 1);
         chk("tmo_error", {31'b0, error}, 1);
         chk("tmo_found", {31'b0, found}, 0);
         chk("tmo_steps", {28'b0, steps}, 0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
